interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Sits between the interrupt sources (timer, later buttons) and the cpu interruptions input.
//  Captures rising edges on up to 8 request lines into pending flags and applies a software mask.
//  Presents one winner at a time to the cpu through a req/ack/done handshake, with fixed priority.
//  Single clock domain; sources wider than one cycle are edge-detected, so level sources fire once.
// PARAMETERS
//  N_IRQ     8          number of request lines (max 8)
//  ID_W      3          width of irq_id; must satisfy 2**ID_W >= N_IRQ
//  MASK_RST  8'hFF      mask value after reset (1 = line enabled)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      asynchronous, active-low; clears all state
//  irq_in      in   N_IRQ  raw request lines from timer/peripherals
//  mask_we     in   1      write strobe for the mask register
//  mask_wdata  in   N_IRQ  new mask value, taken when mask_we=1
//  irq_ack     in   1      cpu accepts the current request (one-cycle pulse)
//  irq_done    in   1      cpu finished the ISR (return-from-interrupt pulse)
//  irq_req     out  1      request to the cpu, held until acknowledged
//  irq_id      out  ID_W   index of the requesting line, stable while irq_req=1 and in service
//  pending     out  N_IRQ  pending flags, readable by software
//  in_service  out  1      high from ack until done
// BEHAVIOUR
//  Reset (reset=0, asynchronous): irq_req=0, irq_id=0, pending=0, in_service=0, mask=MASK_RST,
//   FSM=IDLE, edge-history register=0. Therefore a line already high at reset release is seen
//   as an edge on the first clock.
//  Edge detect: rise[i] = irq_in[i] & ~prev[i]; prev <= irq_in every cycle.
//  pending[i] is set on rise[i], masked or not. It is cleared only when the cpu acks line i.
//   If set and clear of the same bit happen in one cycle, set wins, so a new edge is never lost.
//  Eligible lines = pending & mask. Priority is fixed: the lowest index wins.
//  FSM states IDLE, REQ, SERVICE:
//   IDLE    : if eligible != 0, latch the winner into irq_id, set irq_req=1, go to REQ.
//             Latency: edge at cycle t gives pending at t+1 and irq_req at t+2.
//   REQ     : irq_req=1 and irq_id frozen, even if a higher-priority line arrives.
//             On irq_ack: clear pending[irq_id], irq_req<=0, in_service<=1, go to SERVICE.
//             If the line is masked while in REQ, the request stays up and the ack is honoured.
//   SERVICE : no new request (no nesting). On irq_done: in_service<=0, go to IDLE.
//             A new request can be raised the cycle after IDLE is re-entered.
//  irq_ack outside REQ and irq_done outside SERVICE are ignored.
//  Simultaneous ack and done: only the one valid for the current state is acted on.
//  mask_we takes effect on the next cycle's eligibility and does not alter pending.
//  Lines at index >= N_IRQ do not exist; irq_id never exceeds N_IRQ-1.
// STRUCTURE
//  Shared package/header (irq_defs.vh): FSM state encodings (IDLE=2'd0, REQ=2'd1,
//   SERVICE=2'd2), the default N_IRQ and ID_W, and the default mask.
//  One sub-module, prio_enc: combinational lowest-index-first encoder with outputs found/id.
//  Everything else (edge detect, pending, mask, FSM) stays flat in this module.
// TESTING
//  1) Reset held low, irq_in=8'h01, release -> pending=8'h01 after 1 clk, irq_req=1, irq_id=0
//     after 2 clk.
//  2) irq_in=8'h28 in one cycle -> irq_id=3; ack -> pending=8'h20, in_service=1; done ->
//     irq_req=1, irq_id=5.
//  3) mask=8'hFE, pulse irq_in[0] -> pending[0]=1, irq_req stays 0; write mask=8'hFF ->
//     irq_req=1, irq_id=0.
//  4) Hold irq_in[2] high for 10 cycles -> pending[2] set once; after ack/done, no second
//     request.
//  5) New edge on line 1 in the same cycle as the ack of line 1 -> pending[1] stays 1 and is
//     re-requested after done.
//  6) Assert reset in SERVICE with pending=8'h0C -> all outputs 0 immediately; after release,
//     with irq_in=0, no irq_req.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default sizing.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int         N_IRQ_DEF    = 8;
  localparam int         ID_W_DEF     = 3;
  localparam logic [7:0] MASK_RST_DEF = 8'hFF;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins, zero latency.
module interrupt_controller_prio_enc
  import interrupt_controller_pkg::*;
#(
  parameter int N = N_IRQ_DEF,
  parameter int W = ID_W_DEF
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [W-1:0] id_o
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    found_o = 1'b0;
    id_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        id_o    = W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-captured, maskable, fixed-priority interrupt controller with a req/ack/done cpu handshake.
// Edge to pending takes 1 cycle and pending to irq_req 1 more; no nesting while in service.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int               N_IRQ    = N_IRQ_DEF,
  parameter int               ID_W     = ID_W_DEF,
  parameter logic [N_IRQ-1:0] MASK_RST = MASK_RST_DEF[N_IRQ-1:0]
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_in_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_wdata_i,
  input  logic             irq_ack_i,
  input  logic             irq_done_i,
  output logic             irq_req_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic             in_service_o
);

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  prev_q, pending_q, pending_d, mask_q;
  logic [N_IRQ-1:0]  rise, eligible, clr;
  logic [ID_W-1:0]   irq_id_q, irq_id_d, win_id;
  logic              win_found;

  assign rise     = irq_in_i & ~prev_q;
  assign eligible = pending_q & mask_q;

  interrupt_controller_prio_enc #(
    .N (N_IRQ),
    .W (ID_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .found_o (win_found),
    .id_o    (win_id)
  );

  always_comb begin
    clr = '0;
    if (state_q == ST_REQ && irq_ack_i) begin
      clr[irq_id_q] = 1'b1;
    end
  end

  // A fresh edge on the line being acked re-arms it rather than being swallowed.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      irq_id_q  <= '0;
    end else begin
      prev_q    <= irq_in_i;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
      if (mask_we_i) begin
        mask_q <= mask_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The winner is latched only when leaving IDLE, so irq_id stays frozen through REQ and SERVICE.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_REQ;
          irq_id_d = win_id;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (irq_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_req_o    = (state_q == ST_REQ);
    in_service_o = (state_q == ST_SERVICE);
    irq_id_o     = irq_id_q;
    pending_o    = pending_q;
  end

endmodule
